// File: rtl/packet_replay_source.sv
// packet_replay_source: fetches a stored frame from memory over a pipelined
// Avalon-MM read master and replays it as an Avalon-ST source stream.
module packet_replay_source #(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 32,
  parameter int LENWIDTH            = 14,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]            byte_len,
  output logic                           busy,
  output logic                           done,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic [DATAWIDTH-1:0]           st_data,
  output logic                           st_valid,
  input  logic                           st_ready,
  output logic                           st_sop,
  output logic                           st_eop,
  output logic [1:0]                     st_empty
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PTRW + 1;
  localparam int WCW  = LENWIDTH - 1;
  localparam logic [CNTW:0]   OCC_LIMIT = (CNTW + 1)'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [MASTER_ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [WCW-1:0]                 totalWords_q, totalWords_d;
  logic [WCW-1:0]                 reqCnt_q, reqCnt_d;
  logic [WCW-1:0]                 sentCnt_q, sentCnt_d;
  logic [1:0]                     lenLow_q, lenLow_d;
  logic [CNTW-1:0]                outstanding_q, outstanding_d;
  logic [CNTW-1:0]                fifoCount_q, fifoCount_d;
  logic [PTRW-1:0]                rdPtr_q, rdPtr_d;
  logic [PTRW-1:0]                wrPtr_q, wrPtr_d;
  logic [DATAWIDTH-1:0]           fifoMem [FIFO_DEPTH];

  logic [LENWIDTH:0] lenPlus3;
  logic [WCW-1:0]    wordsIn;
  logic [CNTW:0]     occupancy;
  logic              readAccept;
  logic              push;
  logic              pop;

  // Word count is formed one bit wider so the +3 rounding cannot overflow.
  assign lenPlus3 = {1'b0, byte_len} + (LENWIDTH + 1)'(3);
  assign wordsIn  = WCW'(lenPlus3 >> 2);

  // Slots already claimed: words sitting in the FIFO plus reads still in flight.
  assign occupancy  = {1'b0, fifoCount_q} + {1'b0, outstanding_q};
  assign readAccept = master_read && !master_waitrequest;
  assign push       = master_readdatavalid;
  assign pop        = st_valid && st_ready;

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign master_address = addr_q;
  assign master_read    = (state_q == RUN) && (reqCnt_q < totalWords_q) && (occupancy < OCC_LIMIT);

  assign st_valid = (fifoCount_q != '0);
  assign st_data  = st_valid ? fifoMem[rdPtr_q] : '0;
  assign st_sop   = st_valid && (sentCnt_q == '0);
  assign st_eop   = st_valid && (sentCnt_q == totalWords_q - WCW'(1));
  assign st_empty = st_eop ? (2'd0 - lenLow_q) : 2'd0;

  // Next-state logic: control FSM, read issue, credit counters and FIFO pointers.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    totalWords_d  = totalWords_q;
    reqCnt_d      = reqCnt_q;
    sentCnt_d     = sentCnt_q;
    lenLow_d      = lenLow_q;
    outstanding_d = outstanding_q;
    fifoCount_d   = fifoCount_q;
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          reqCnt_d  = '0;
          sentCnt_d = '0;
          if (byte_len != '0) begin
            state_d      = RUN;
            addr_d       = base_addr & ~(MASTER_ADDRESSWIDTH'(3));
            totalWords_d = wordsIn;
            lenLow_d     = byte_len[1:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (pop && st_eop) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (readAccept) begin
      reqCnt_d = reqCnt_q + WCW'(1);
      addr_d   = addr_q + MASTER_ADDRESSWIDTH'(4);
    end

    if (pop) begin
      sentCnt_d = sentCnt_q + WCW'(1);
      rdPtr_d   = rdPtr_q + PTRW'(1);
    end

    if (push) wrPtr_d = wrPtr_q + PTRW'(1);

    case ({readAccept, push})
      2'b10:   outstanding_d = outstanding_q + CNTW'(1);
      2'b01:   outstanding_d = outstanding_q - CNTW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + CNTW'(1);
      2'b01:   fifoCount_d = fifoCount_q - CNTW'(1);
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  // State and counter registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      totalWords_q  <= '0;
      reqCnt_q      <= '0;
      sentCnt_q     <= '0;
      lenLow_q      <= '0;
      outstanding_q <= '0;
      fifoCount_q   <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      totalWords_q  <= totalWords_d;
      reqCnt_q      <= reqCnt_d;
      sentCnt_q     <= sentCnt_d;
      lenLow_q      <= lenLow_d;
      outstanding_q <= outstanding_d;
      fifoCount_q   <= fifoCount_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
    end
  end

  // Prefetch storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr_q] <= master_readdata;
  end

  // The read credit rule must keep a returning word from landing in a full FIFO.
  fifoNoOverflow: assert property (@(posedge clk) disable iff (!n_rst)
    (push && !pop) |-> (fifoCount_q != FIFO_FULL));

endmodule

// File: tb/tb_packet_replay_source.sv
// tb_packet_replay_source: directed bench for packet_replay_source with a
// one-cycle-latency memory model, optional wait states and sink backpressure.
module tb_packet_replay_source;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] byte_len;
  logic          busy;
  logic          done;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic [DW-1:0] master_readdata;
  logic          master_readdatavalid;
  logic          master_waitrequest;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready;
  logic          st_sop;
  logic          st_eop;
  logic [1:0]    st_empty;

  int checksDone   = 0;
  int checksPassed = 0;

  // Memory model state
  logic          rdvQ;
  logic [DW-1:0] rdataQ;
  int            waitCnt;
  bit            stallMode = 0;
  int            acceptedCnt;
  logic [31:0]   addrQ[$];

  // Stream monitor state
  logic [31:0] dataQ[$];
  logic [31:0] sopQ[$];
  logic [31:0] eopQ[$];
  logic [31:0] emptyQ[$];
  int cyc = 0;
  int wordsSeen, doneCnt, doneCycle, eopCycle, startCycle;
  int firstReadCycle, firstRdvCycle, firstValidCycle, maxOcc;
  bit readSeen, sawReadIdle;
  bit prevDone, prevStall, prevHeld;
  logic [AW-1:0] prevAddr;
  logic [DW-1:0] prevData;
  logic          prevSop, prevEop;
  logic [1:0]    prevEmpty;

  // Backpressure control
  bit bpMode = 0;
  int bpCnt;

  packet_replay_source #(
    .MASTER_ADDRESSWIDTH(AW), .DATAWIDTH(DW), .LENWIDTH(LW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr), .byte_len(byte_len),
    .busy(busy), .done(done), .master_address(master_address), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [AW-1:0] a);
    return {6'h2A, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  assign master_readdatavalid = rdvQ;
  assign master_readdata      = rdataQ;
  assign master_waitrequest   = stallMode && (waitCnt < 3);

  // Cycle counter used for latency measurements
  always @(posedge clk) cyc++;

  // Memory slave: accepted reads return one cycle later; stalls add 3 wait cycles per read
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdvQ    <= 1'b0;
      rdataQ  <= '0;
      waitCnt <= 0;
    end else begin
      rdvQ   <= master_read && !master_waitrequest;
      rdataQ <= memWord(master_address);
      if (master_read && !master_waitrequest) begin
        waitCnt <= 0;
        acceptedCnt++;
        addrQ.push_back(32'(master_address));
      end else if (master_read) begin
        waitCnt <= waitCnt + 1;
      end
    end
  end

  // Sink ready: low for 10 cycles after the first word when backpressure is on
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bpMode && wordsSeen >= 1 && bpCnt < 10) begin
        st_ready = 1'b0;
        bpCnt++;
      end else begin
        st_ready = 1'b1;
      end
    end
  end

  // Mid-cycle monitor: records transfers, latencies and hold behaviour
  always @(negedge clk) begin
    if (!n_rst) begin
      prevDone  = 0;
      prevStall = 0;
      prevHeld  = 0;
    end else begin
      if ((acceptedCnt - wordsSeen) > maxOcc) maxOcc = acceptedCnt - wordsSeen;
      if (master_read) readSeen = 1;
      if (master_read && firstReadCycle < 0) firstReadCycle = cyc;
      if (master_readdatavalid && firstRdvCycle < 0) firstRdvCycle = cyc;
      if (st_valid && firstValidCycle < 0) firstValidCycle = cyc;
      if (st_valid && !st_ready && !master_read) sawReadIdle = 1;
      if (prevDone) checkOutput("busy_after_done", 32'(busy), 32'd0);
      if (done) begin
        doneCnt++;
        doneCycle = cyc;
        checkOutput("busy_with_done", 32'(busy), 32'd1);
      end
      if (prevStall) begin
        checkOutput("stall_read_held", 32'(master_read), 32'd1);
        checkOutput("stall_addr_held", 32'(master_address), 32'(prevAddr));
      end
      if (prevHeld) begin
        checkOutput("hold_valid", 32'(st_valid), 32'd1);
        checkOutput("hold_data", st_data, prevData);
        checkOutput("hold_sop", 32'(st_sop), 32'(prevSop));
        checkOutput("hold_eop", 32'(st_eop), 32'(prevEop));
        checkOutput("hold_empty", 32'(st_empty), 32'(prevEmpty));
      end
      if (st_valid && st_ready) begin
        dataQ.push_back(st_data);
        sopQ.push_back(32'(st_sop));
        eopQ.push_back(32'(st_eop));
        emptyQ.push_back(32'(st_empty));
        if (st_eop) eopCycle = cyc;
        wordsSeen++;
      end
      prevDone  = done;
      prevStall = master_read && master_waitrequest;
      prevAddr  = master_address;
      prevHeld  = st_valid && !st_ready;
      prevData  = st_data;
      prevSop   = st_sop;
      prevEop   = st_eop;
      prevEmpty = st_empty;
    end
  end

  task automatic checkResetOutputs();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_master_read", 32'(master_read), 32'd0);
    checkOutput("rst_master_address", 32'(master_address), 32'd0);
    checkOutput("rst_st_valid", 32'(st_valid), 32'd0);
    checkOutput("rst_st_sop", 32'(st_sop), 32'd0);
    checkOutput("rst_st_eop", 32'(st_eop), 32'd0);
    checkOutput("rst_st_data", st_data, 32'd0);
    checkOutput("rst_st_empty", 32'(st_empty), 32'd0);
  endtask

  // Compare everything recorded for one frame against the hand-derived expectation
  task automatic checkFrame(input logic [AW-1:0] base, input int len);
    int words;
    logic [AW-1:0] a;
    words = (len + 3) / 4;
    checkOutput("done_pulses", 32'(doneCnt), 32'd1);
    checkOutput("read_count", 32'(addrQ.size()), 32'(words));
    checkOutput("word_count", 32'(dataQ.size()), 32'(words));
    for (int i = 0; i < addrQ.size() && i < words; i++) begin
      a = base + AW'(4 * i);
      checkOutput("read_addr", addrQ[i], 32'(a));
    end
    for (int i = 0; i < dataQ.size() && i < words; i++) begin
      a = base + AW'(4 * i);
      checkOutput("data", dataQ[i], memWord(a));
      checkOutput("sop", sopQ[i], (i == 0) ? 32'd1 : 32'd0);
      checkOutput("eop", eopQ[i], (i == words - 1) ? 32'd1 : 32'd0);
      checkOutput("empty", emptyQ[i], (i == words - 1) ? 32'((4 - len % 4) % 4) : 32'd0);
    end
    if (words > 0) begin
      checkOutput("first_read_latency", 32'(firstReadCycle - startCycle), 32'd1);
      checkOutput("first_valid_latency", 32'(firstValidCycle - firstRdvCycle), 32'd1);
      checkOutput("done_after_eop", 32'(doneCycle - eopCycle), 32'd1);
      checkOutput("occupancy_le4", 32'(maxOcc <= 4), 32'd1);
    end else begin
      checkOutput("no_reads", 32'(readSeen), 32'd0);
      checkOutput("zero_len_done_latency", 32'(doneCycle - startCycle), 32'd1);
    end
  endtask

  // Run one frame: pulse start, optionally retry start while busy, wait for done
  task automatic applyStimulus(input logic [AW-1:0] base, input int len, input bit extraStart);
    int t;
    @(posedge clk);
    #1;
    addrQ.delete(); dataQ.delete(); sopQ.delete(); eopQ.delete(); emptyQ.delete();
    acceptedCnt = 0; wordsSeen = 0; doneCnt = 0; doneCycle = -1; eopCycle = -1;
    firstReadCycle = -1; firstRdvCycle = -1; firstValidCycle = -1; maxOcc = 0;
    readSeen = 0; sawReadIdle = 0; bpCnt = 0;
    base_addr = base;
    byte_len  = LW'(len);
    start     = 1'b1;
    startCycle = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = '1;
    byte_len  = '1;
    if (extraStart) begin
      repeat (3) @(posedge clk);
      #1;
      start    = 1'b1;
      byte_len = LW'(4);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    t = 0;
    while (doneCnt == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("done_seen", 32'(doneCnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkFrame(base, len);
  endtask

  initial begin
    n_rst     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    byte_len  = '0;
    #1;
    checkResetOutputs();
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    $display("[TB] two-word frame");
    applyStimulus(26'h0000100, 8, 0);

    $display("[TB] 61-byte frame at full rate");
    applyStimulus(26'h0001000, 61, 0);
    checkOutput("full_rate", 32'(eopCycle - firstValidCycle), 32'd15);

    $display("[TB] single-word frame");
    applyStimulus(26'h0002000, 3, 0);

    $display("[TB] sink backpressure");
    bpMode = 1;
    applyStimulus(26'h0003000, 64, 0);
    bpMode = 0;
    checkOutput("bp_read_throttled", 32'(sawReadIdle), 32'd1);
    checkOutput("bp_occupancy_peak", 32'(maxOcc), 32'd4);

    $display("[TB] memory wait states");
    stallMode = 1;
    applyStimulus(26'h0004000, 12, 0);
    stallMode = 0;

    $display("[TB] zero-length frame");
    applyStimulus(26'h0005000, 0, 0);

    $display("[TB] start while busy");
    applyStimulus(26'h0006000, 16, 1);

    $display("[TB] reset mid-frame");
    @(posedge clk);
    #1;
    base_addr = 26'h0007000;
    byte_len  = LW'(64);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checkResetOutputs();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;

    $display("[TB] replay after reset");
    applyStimulus(26'h0008000, 8, 0);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
